// File: rtl/ib_div_pkg.sv
// Shared definitions for the ib_div sequential divider family: state
// encoding and default operand widths.
package ib_div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/ib_div_step.sv
// One restoring-division iteration: shifts the next dividend bit into the
// partial remainder, trial-subtracts the divisor and emits one quotient bit.
// Purely combinational so unrolled variants can chain several per cycle.
module ib_div_step
  import ib_div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   p,
  input  logic          msb,
  input  logic [VW-1:0] div,
  output logic [VW:0]   p_nxt,
  output logic          qbit
);

  // The remainder never exceeds VW bits after a subtraction, so the top
  // bit of p carries no information into the next step.
  logic unused_p_top;
  assign unused_p_top = p[VW];

  logic [VW:0] t;

  // Shift, compare in VW+1 bits so the shifted-out carry is kept, restore.
  always_comb begin
    t = {p[VW-1:0], msb};
    if (t >= {1'b0, div}) begin
      p_nxt = t - {1'b0, div};
      qbit  = 1'b1;
    end else begin
      p_nxt = t;
      qbit  = 1'b0;
    end
  end

endmodule

// File: rtl/ib_div_16x8_s0_l16.sv
// Sequential restoring divider, unsigned DW / VW, one quotient bit per cycle.
// Uses the ib_mul start/done handshake: o_done is high whenever the block is
// idle and no start is being presented.
// Optional feature macro: IB_DIV_DBZ_EN -- adds o_dbz and resolves a zero
// divisor in a single cycle instead of running the full iteration.
module ib_div_16x8_s0_l16
  import ib_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [VW-1:0] i_b,
  output logic [DW-1:0] o_q,
  output logic [VW-1:0] o_r,
`ifdef IB_DIV_DBZ_EN
  output logic          o_dbz,
`endif
  output logic          o_done
);

  localparam int CW = $clog2(DW + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] sr;
  logic [VW:0]   p;
  logic [VW-1:0] div;
  logic [CW-1:0] cnt;
  logic [VW:0]   p_nxt;
  logic          qbit;
  logic          zero_div;

  assign zero_div = (i_b == '0);

  ib_div_step #(.VW(VW)) u_step (
    .p     (p),
    .msb   (sr[DW-1]),
    .div   (div),
    .p_nxt (p_nxt),
    .qbit  (qbit)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state: a start always (re)launches; the last iteration returns to idle.
  always_comb begin
    state_nxt = state;
    if (i_start) begin
`ifdef IB_DIV_DBZ_EN
      state_nxt = zero_div ? ST_IDLE : ST_BUSY;
`else
      state_nxt = ST_BUSY;
`endif
    end else if (state == ST_BUSY && cnt == CW'(1)) begin
      state_nxt = ST_IDLE;
    end
  end

  // Datapath: capture operands on start, iterate while busy, hold otherwise.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sr  <= '0;
      p   <= '0;
      div <= '0;
      cnt <= '0;
    end else if (i_start) begin
      div <= i_b;
`ifdef IB_DIV_DBZ_EN
      if (zero_div) begin
        sr  <= '1;
        p   <= {1'b0, i_a[VW-1:0]};
        cnt <= '0;
      end else begin
        sr  <= i_a;
        p   <= '0;
        cnt <= CW'(DW);
      end
`else
      sr  <= i_a;
      p   <= '0;
      cnt <= CW'(DW);
`endif
    end else if (state == ST_BUSY) begin
      sr  <= {sr[DW-2:0], qbit};
      p   <= p_nxt;
      cnt <= cnt - CW'(1);
    end
  end

`ifdef IB_DIV_DBZ_EN
  logic dbz;

  // Divide-by-zero flag: refreshed on every start, cleared by reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)      dbz <= 1'b0;
    else if (i_start) dbz <= zero_div;
  end

  assign o_dbz = dbz;
`endif

  assign o_q    = sr;
  assign o_r    = p[VW-1:0];
  assign o_done = ~i_start & (state == ST_IDLE);

endmodule
